reg_file_sb: RTL and testbench

Parametrised register file for the 6-stage MIPS pipeline. Provides two registered read ports, one write port, and optional hardwired-zero r0 and write-to-read bypass. Adds a per-register pending-write scoreboard so decode can stall on registers with outstanding long-latency writes (loads). Sits in the ID stage; written from WB.

---
 rtl/mips_pkg.sv | 11 +
 rtl/reg_scoreboard.sv | 58 +++++
 rtl/reg_file_sb.sv | 107 ++++++++++
 tb/tb_reg_file_sb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants for the MIPS pipeline register file
//
// Purpose : register file geometry and the hardwired-zero register index.
// Ports   : none (package).
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_ZERO   = 0;

endpackage : mips_pkg

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write scoreboard for long-latency register writes
//
// Purpose : one pending bit per register; set by a reservation (load issued),
//           cleared by the write-back, and looked up for the two read ports.
// Ports   : clk, rst (async active-low)
//           rsv_en/rsv_addr   - mark a register pending
//           wr_en/wr_addr     - write-back, clears the pending bit
//           rd_addr1/rd_addr2 - lookup addresses
//           busy1/busy2       - lookup result (combinational, masked)
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              busy1,
  output logic              busy2
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // Clear first, then set: a reservation made in the same cycle as an older
  // write-back to the same register must survive.
  always_comb begin
    pending_d = pending_q;
    if (wr_en) pending_d[wr_addr] = 1'b0;
    if (rsv_en && !(ZERO_REG != 0 && rsv_addr == ZERO_ADDR)) pending_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  // A register being written this cycle is not busy when its value is forwarded.
  always_comb begin
    busy1 = pending_q[rd_addr1];
    if (ZERO_REG != 0 && rd_addr1 == ZERO_ADDR) busy1 = 1'b0;
    if (BYPASS != 0 && wr_en && wr_addr == rd_addr1) busy1 = 1'b0;
    busy2 = pending_q[rd_addr2];
    if (ZERO_REG != 0 && rd_addr2 == ZERO_ADDR) busy2 = 1'b0;
    if (BYPASS != 0 && wr_en && wr_addr == rd_addr2) busy2 = 1'b0;
  end

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 2R1W register file with bypass, zero register and scoreboard
//
// Purpose : ID-stage register file written from WB; registered read ports,
//           optional hardwired r0 and write-to-read forwarding, plus a
//           pending-write scoreboard that raises stall on load-use hazards.
// Ports   : clk, rst (async active-low)
//           rd_en, rd_addr1/2 -> rd_data1/2 (one-cycle latency)
//           wr_en, wr_addr, wr_data (WB write port)
//           rsv_en, rsv_addr (reserve a register as pending)
//           busy1/2, stall (combinational hazard indication)
module reg_file_sb
  import mips_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              stall
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
  logic [DATA_W-1:0] src1, src2;
  logic              wr_ok;

  assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == ZERO_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read source priority: zero register, then forwarded write data, then storage.
  always_comb begin
    src1 = mem_q[rd_addr1];
    if (BYPASS != 0 && wr_en && wr_addr == rd_addr1) src1 = wr_data;
    if (ZERO_REG != 0 && rd_addr1 == ZERO_ADDR) src1 = '0;
    src2 = mem_q[rd_addr2];
    if (BYPASS != 0 && wr_en && wr_addr == rd_addr2) src2 = wr_data;
    if (ZERO_REG != 0 && rd_addr2 == ZERO_ADDR) src2 = '0;
  end

  always_comb begin
    rd_data1_d = rd_data1_q;
    rd_data2_d = rd_data2_q;
    if (rd_en) begin
      rd_data1_d = src1;
      rd_data2_d = src2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data1_q <= '0;
      rd_data2_q <= '0;
    end else begin
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
    end
  end

  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2),
    .busy1   (busy1),
    .busy2   (busy2)
  );

  // The read is still captured while stalled; decode re-issues it.
  assign stall = rd_en && (busy1 || busy2);

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb (two configurations)
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        b1_a, b2_a, st_a, b1_b, b2_b, st_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance a: ZERO_REG=1, BYPASS=1. Instance b: ZERO_REG=0, BYPASS=0.
  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1_a), .rd_data2(rd2_a), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(b1_a), .busy2(b2_a), .stall(st_a)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1_b), .rd_data2(rd2_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(b1_b), .busy2(b2_b), .stall(st_b)
  );

  // Reference model: index 0 = config a, index 1 = config b.
  logic [31:0] mem_m [2][32];
  bit          pend_m [2][32];
  logic [31:0] rd_m [2][2];
  bit          zr_c [2] = '{1'b1, 1'b0};
  bit          bp_c [2] = '{1'b1, 1'b0};

  function automatic logic [31:0] src_m(int c, logic [4:0] a);
    if (zr_c[c] && a == 5'd0) return 32'd0;
    if (bp_c[c] && wr_en && wr_addr == a) return wr_data;
    return mem_m[c][a];
  endfunction

  function automatic bit busy_m(int c, logic [4:0] a);
    if (zr_c[c] && a == 5'd0) return 1'b0;
    if (bp_c[c] && wr_en && wr_addr == a) return 1'b0;
    return pend_m[c][a];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 32; i++) begin
        mem_m[c][i] = 32'd0;
        pend_m[c][i] = 1'b0;
      end
      rd_m[c][0] = 32'd0;
      rd_m[c][1] = 32'd0;
    end
  endtask

  // Applies the current inputs as one rising edge in the model.
  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      if (rd_en) begin
        rd_m[c][0] = src_m(c, rd_addr1);
        rd_m[c][1] = src_m(c, rd_addr2);
      end
      if (wr_en && !(zr_c[c] && wr_addr == 5'd0)) mem_m[c][wr_addr] = wr_data;
      if (wr_en) pend_m[c][wr_addr] = 1'b0;
      if (rsv_en && !(zr_c[c] && rsv_addr == 5'd0)) pend_m[c][rsv_addr] = 1'b1;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_comb();
    check("busy1_a", 32'(b1_a), 32'(busy_m(0, rd_addr1)));
    check("busy2_a", 32'(b2_a), 32'(busy_m(0, rd_addr2)));
    check("stall_a", 32'(st_a), 32'(rd_en && (busy_m(0, rd_addr1) || busy_m(0, rd_addr2))));
    check("busy1_b", 32'(b1_b), 32'(busy_m(1, rd_addr1)));
    check("busy2_b", 32'(b2_b), 32'(busy_m(1, rd_addr2)));
    check("stall_b", 32'(st_b), 32'(rd_en && (busy_m(1, rd_addr1) || busy_m(1, rd_addr2))));
  endtask

  task automatic check_data();
    check("rd_data1_a", rd1_a, rd_m[0][0]);
    check("rd_data2_a", rd2_a, rd_m[0][1]);
    check("rd_data1_b", rd1_b, rd_m[1][0]);
    check("rd_data2_b", rd2_b, rd_m[1][1]);
  endtask

  task automatic idle();
    rd_en = 1'b0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    rsv_en = 1'b0; rsv_addr = 5'd0;
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_data();
    @(negedge clk);
  endtask

  task automatic drive(bit re, logic [4:0] a1, logic [4:0] a2, bit we, logic [4:0] wa,
                       logic [31:0] wd, bit rv, logic [4:0] ra);
    rd_en = re; rd_addr1 = a1; rd_addr2 = a2;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = rv; rsv_addr = ra;
    cycle();
  endtask

  task automatic async_reset_check();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rd1_a", rd1_a, 32'd0);
    check("async_rd2_a", rd2_a, 32'd0);
    check("async_rd1_b", rd1_b, 32'd0);
    check("async_busy_a", 32'({b1_a, b2_a, st_a}), 32'd0);
    check("async_busy_b", 32'({b1_b, b2_b, st_b}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_data();
    rd_en = 1'b1; rd_addr1 = 5'd3;
    #1;
    check_comb();
    rst = 1'b1;
    idle();

    // Reset then read r5/r31.
    drive(1, 5'd5, 5'd31, 0, 0, 0, 0, 0);
    // Write r7, then read it.
    drive(0, 0, 0, 1, 5'd7, 32'hDEADBEEF, 0, 0);
    drive(1, 5'd7, 5'd5, 0, 0, 0, 0, 0);
    // Zero register write/read.
    drive(0, 0, 0, 1, 5'd0, 32'h12345678, 0, 0);
    drive(1, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    // Bypass: old r9 value, then same-cycle write+read.
    drive(0, 0, 0, 1, 5'd9, 32'h11111111, 0, 0);
    drive(1, 5'd7, 5'd9, 1, 5'd9, 32'hA5A5A5A5, 0, 0);
    drive(1, 5'd9, 5'd9, 0, 0, 0, 0, 0);
    // Load-use: reserve r3, read, write back, read again.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd3);
    drive(1, 5'd3, 5'd0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5'd3, 32'h55, 0, 0);
    drive(1, 5'd3, 5'd0, 0, 0, 0, 0, 0);
    // Reservation of r0 (ignored only when r0 is hardwired).
    drive(0, 0, 0, 0, 0, 0, 1, 5'd0);
    drive(1, 5'd0, 5'd1, 0, 0, 0, 0, 0);
    // Set/clear collision on r4.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd4);
    drive(1, 5'd4, 5'd4, 1, 5'd4, 32'h44, 1, 5'd4);
    drive(1, 5'd4, 5'd7, 0, 0, 0, 0, 0);
    async_reset_check();

    // Randomised traffic with a few mid-run resets.
    for (int n = 0; n < 400; n++) begin
      rd_en    = 1'($urandom_range(0, 3) != 0);
      rd_addr1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rd_addr2 = 5'($urandom_range(0, 7));
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 5'($urandom_range(0, 7));
      wr_data  = $urandom();
      rsv_en   = 1'($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 7));
      cycle();
      if (n % 137 == 136) begin
        idle();
        async_reset_check();
      end
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_sb
